// File: rtl/fc_stream_host.sv
// fc_stream_host: streams a captured N-element vector to a fully-connected
// layer one element at a time, collects M result elements back, and
// presents them as one wide result vector until the consumer takes it.
module fc_stream_host #(
    parameter int M = 16,
    parameter int N = 8,
    parameter int T = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [N*T-1:0]      vec_in,
    output logic                x_valid,
    input  logic                x_ready,
    output logic signed [T-1:0] x_data,
    input  logic                y_valid,
    output logic                y_ready,
    input  logic signed [T-1:0] y_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [M*T-1:0]      res_vec,
    output logic                busy
);

    localparam int TXW = $clog2(N + 1);
    localparam int RXW = $clog2(M + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_reg;
    logic [TXW-1:0] tx_cnt_reg;
    logic [RXW-1:0] rx_cnt_reg;
    logic [N*T-1:0] vec_reg;

    logic start_hs;
    logic x_hs;
    logic y_hs;
    logic tx_last;
    logic rx_done_next;

    // Handshake outputs are pure decodes of registered state, so no input
    // reaches an output combinationally.
    assign start_ready = (state_reg == IDLE);
    assign x_valid     = (state_reg == SEND);
    assign res_valid   = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign y_ready     = ((state_reg == SEND) || (state_reg == RECV)) &&
                         (rx_cnt_reg < RXW'(M));

    assign start_hs = start_valid && start_ready;
    assign x_hs     = x_valid && x_ready;
    assign y_hs     = y_valid && y_ready;

    // Last input element leaves this cycle.
    assign tx_last = x_hs && (tx_cnt_reg == TXW'(N - 1));

    // Result collection is complete either already or with this cycle's capture.
    assign rx_done_next = (rx_cnt_reg == RXW'(M)) ||
                          (y_hs && (rx_cnt_reg == RXW'(M - 1)));

    // Select stored element tx_cnt for the layer input.
    always_comb begin
        x_data = '0;
        for (int i = 0; i < N; i++) begin
            if (tx_cnt_reg == TXW'(i)) begin
                x_data = vec_reg[i*T +: T];
            end
        end
    end

    // Request sequencing: capture, stream out, collect, hand over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            tx_cnt_reg <= '0;
            rx_cnt_reg <= '0;
            vec_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_hs) begin
                        vec_reg    <= vec_in;
                        tx_cnt_reg <= '0;
                        rx_cnt_reg <= '0;
                        state_reg  <= SEND;
                    end
                end
                SEND: begin
                    if (tx_last) begin
                        state_reg <= rx_done_next ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (rx_done_next) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Counters advance only on handshakes and saturate at N and M;
            // x and y handshakes in the same cycle are both taken.
            if (x_hs && (tx_cnt_reg < TXW'(N))) begin
                tx_cnt_reg <= tx_cnt_reg + 1'b1;
            end
            if (y_hs && (rx_cnt_reg < RXW'(M))) begin
                rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
        end
    end

    // One register per result element; written only by the y handshake that
    // targets it, so the previous result persists through IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_res
            logic [T-1:0] elem_reg;

            // Capture the arriving layer result into slot gi.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    elem_reg <= '0;
                end else if (y_hs && (rx_cnt_reg == RXW'(gi))) begin
                    elem_reg <= y_data;
                end
            end

            assign res_vec[gi*T +: T] = elem_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fc_stream_host.sv
// tb_fc_stream_host: directed bench with a simple layer model (all-ones
// weights, or a fixed alternating pattern) driving fc_stream_host.
module tb_fc_stream_host;

    localparam int M = 16;
    localparam int N = 8;
    localparam int T = 8;

    logic                clk;
    logic                reset;
    logic                start_valid;
    logic                start_ready;
    logic [N*T-1:0]      vec_in;
    logic                x_valid;
    logic                x_ready;
    logic signed [T-1:0] x_data;
    logic                y_valid;
    logic                y_ready;
    logic signed [T-1:0] y_data;
    logic                res_valid;
    logic                res_ready;
    logic [M*T-1:0]      res_vec;
    logic                busy;

    int checks;
    int errors;

    fc_stream_host #(.M(M), .N(N), .T(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .vec_in      (vec_in),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .y_data      (y_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_vec     (res_vec),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [M*T-1:0] obs,
                            input logic [M*T-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start_ready"}, start_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_x_valid"}, x_valid, 0);
        check_eq({tag, "_y_ready"}, y_ready, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_vec"}, res_vec, '0);
    endtask

    // Issue one request with vec_in = 1..N and run the layer model until the
    // result is presented. xtog: x_ready pattern 1,0,0,1,0,0...
    // ymode 0: after all inputs, return M copies of the sum (all-ones weights).
    // ymode 1: return -128/127 alternating, starting during SEND.
    task automatic run_request(input bit xtog, input bit ymode, input bit hold_y);
        int nx;
        int ny;
        int sum;
        logic [T-1:0] e;
        logic [M*T-1:0] snap;

        for (int i = 0; i < N; i++) vec_in[i*T +: T] = T'(i + 1);
        start_valid = 1'b1;
        check_eq("start_ready", start_ready, 1);
        step();
        start_valid = 1'b0;
        check_eq("first_x_valid", x_valid, 1);

        nx = 0;
        ny = 0;
        sum = 0;
        for (int k = 0; k < 300 && !res_valid; k++) begin
            x_ready = xtog ? (k % 3 == 0) : 1'b1;
            y_valid = (ymode || nx == N) && (ny < M);
            y_data  = ymode ? ((ny % 2 == 0) ? T'(-128) : T'(127)) : T'(sum);
            if (x_valid) begin
                check_eq("x_data", x_data, T'(nx + 1));
                if (x_ready) begin
                    sum += nx + 1;
                    nx++;
                end
            end
            if (y_valid && y_ready) ny++;
            step();
        end
        x_ready = 1'b0;
        y_valid = 1'b0;
        $display("request xtog=%0d ymode=%0d: x transfers %0d, y transfers %0d",
                 xtog, ymode, nx, ny);

        check_eq("res_valid", res_valid, 1);
        check_eq("x_count", nx, N);
        check_eq("y_count", ny, M);
        for (int j = 0; j < M; j++) begin
            if (ymode) e = (j % 2 == 0) ? 8'h80 : 8'h7f;
            else       e = 8'd36;
            check_eq("res_elem", res_vec[j*T +: T], e);
        end

        if (hold_y) begin
            snap = res_vec;
            y_valid = 1'b1;
            y_data  = 8'sd55;
            for (int k = 0; k < 3; k++) begin
                check_eq("y_ready_full", y_ready, 0);
                step();
                check_eq("res_vec_no17", res_vec, snap);
            end
            y_valid = 1'b0;
        end
    endtask

    // Hold res_ready low for 'hold' cycles with a new start offered, then
    // take the result and confirm the return to IDLE.
    task automatic complete(input int hold);
        logic [M*T-1:0] snap;
        snap = res_vec;
        if (hold > 0) begin
            start_valid = 1'b1;
            vec_in = {N{8'h55}};
            for (int k = 0; k < hold; k++) begin
                check_eq("done_res_valid", res_valid, 1);
                check_eq("done_start_ready", start_ready, 0);
                check_eq("done_res_vec", res_vec, snap);
                step();
            end
            start_valid = 1'b0;
            check_eq("done_x_valid", x_valid, 0);
        end
        res_ready = 1'b1;
        check_eq("hs_res_valid", res_valid, 1);
        check_eq("hs_start_ready", start_ready, 0);
        step();
        res_ready = 1'b0;
        check_eq("idle_start_ready", start_ready, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_res_valid", res_valid, 0);
        check_eq("idle_res_hold", res_vec, snap);
        step();
        check_eq("idle_res_hold2", res_vec, snap);
        $display("result taken after %0d stall cycles", hold);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        start_valid = 1'b0;
        vec_in = '0;
        x_ready = 1'b0;
        y_valid = 1'b0;
        y_data = '0;
        res_ready = 1'b0;

        #12;
        check_reset_outputs("por");
        reset = 1'b1;
        step();
        check_eq("post_reset_start_ready", start_ready, 1);

        // Always-ready paths, all-ones weights.
        run_request(1'b0, 1'b0, 1'b0);
        complete(0);

        // x_ready stalls, then consumer stalls 10 cycles with a new start offered.
        run_request(1'b1, 1'b0, 1'b0);
        complete(10);

        // Extreme values, overlapping x/y handshakes, y_valid held past M.
        run_request(1'b0, 1'b1, 1'b1);
        complete(0);

        // Abort after 3 x transfers.
        for (int i = 0; i < N; i++) vec_in[i*T +: T] = T'(i + 1);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        x_ready = 1'b1;
        step();
        step();
        step();
        check_eq("pre_abort_x_data", x_data, 4);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        x_ready = 1'b0;
        $display("reset applied after 3 x transfers");
        #3;
        reset = 1'b1;
        step();

        // Restart must begin again at element 0.
        run_request(1'b0, 1'b0, 1'b0);
        complete(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
